// File: rtl/orbit_frame_former.sv
// orbit_frame_former: runtime-moded Orbita telemetry frame former on the system clock.
// Serialises frames of words from a synchronous buffer; mode changes apply only at word 0.
module orbit_frame_former #(
    parameter int WORD_W   = 12,
    parameter int ADDR_W   = 11,
    parameter int BASE_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic [WORD_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              serial,
    output logic              frame_start,
    output logic              grp_odd,
    output logic [2:0]        mode_act
);
    localparam int PW = $clog2(BASE_DIV * 16);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [1:0] PRIME = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]        state;
    logic [PW-1:0]     prescaler;
    logic [BW-1:0]     bitIdx;
    logic [ADDR_W-1:0] wordCnt;
    logic [ADDR_W-1:0] nextWord;
    logic [WORD_W-1:0] prefetch;
    logic [WORD_W-1:0] shift;
    logic              rdPend;
    logic              firstFrame;
    logic [2:0]        modeSat;
    logic [2:0]        modeEff;
    logic              tick;
    logic              wordTick;
    logic              frameTick;

    function automatic logic [PW-1:0] reloadOf(input logic [2:0] m);
        return PW'((BASE_DIV << (4 - int'(m))) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] maskOf(input logic [2:0] m);
        return ADDR_W'((64'd1 << (ADDR_W - 4 + int'(m))) - 64'd1);
    endfunction

    assign modeSat   = (mode > 3'd4) ? 3'd4 : mode;
    assign tick      = (state == RUN) && (prescaler == '0);
    assign wordTick  = tick && (bitIdx == '0);
    assign frameTick = wordTick && (wordCnt == '0);
    // The word-0 tick already runs under the newly sampled mode: its period and frame length.
    assign modeEff   = frameTick ? modeSat : mode_act;
    assign nextWord  = (wordCnt + 1'b1) & maskOf(modeEff);
    assign rd_en     = reset && ((state == PRIME) || wordTick);
    assign rd_addr   = wordTick ? nextWord : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= PRIME;
            prescaler   <= '0;
            bitIdx      <= '0;
            wordCnt     <= '0;
            prefetch    <= '0;
            shift       <= '0;
            rdPend      <= 1'b0;
            firstFrame  <= 1'b1;
            serial      <= 1'b0;
            frame_start <= 1'b0;
            grp_odd     <= 1'b0;
            mode_act    <= 3'd4;
        end else begin
            rdPend      <= rd_en;
            frame_start <= frameTick;
            if (rdPend) prefetch <= rd_data;
            if (state == PRIME) begin
                mode_act <= modeSat;
                state    <= FILL;
            end else if (state == FILL) begin
                prescaler <= '0;
                bitIdx    <= '0;
                wordCnt   <= '0;
                state     <= RUN;
            end else if (tick) begin
                prescaler <= reloadOf(modeEff);
                bitIdx    <= (bitIdx == BW'(WORD_W - 1)) ? '0 : bitIdx + 1'b1;
                serial    <= wordTick ? prefetch[WORD_W-1] : shift[WORD_W-1];
                shift     <= (wordTick ? prefetch : shift) << 1;
                if (wordTick) wordCnt <= nextWord;
                if (frameTick) begin
                    mode_act   <= modeSat;
                    firstFrame <= 1'b0;
                    grp_odd    <= grp_odd ^ ~firstFrame;
                end
            end else begin
                prescaler <= prescaler - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_orbit_frame_former.sv
// tb_orbit_frame_former: time-arithmetic reference model of the frame former plus literal spot checks.
// Cycle n = the clock edge n after reset release; registered outputs are seen at the following negedge.
module tb_orbit_frame_former;
    localparam int WW    = 12;
    localparam int AW    = 6;
    localparam int BD    = 4;
    localparam int FRAME = (1 << AW) * WW * BD;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    mode = 3'd4;
    logic [WW-1:0] rd_data = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          serial;
    logic          frame_start;
    logic          grp_odd;
    logic [2:0]    mode_act;

    logic [WW-1:0] mem [1 << AW];
    int            readCnt [1 << AW];
    int            nChk = 0;
    int            nFail = 0;
    int            sc = -1;
    bit            scbOn = 1'b0;

    orbit_frame_former #(.WORD_W(WW), .ADDR_W(AW), .BASE_DIV(BD)) dut (
        .clk(clk), .reset(reset), .mode(mode), .rd_data(rd_data), .rd_en(rd_en),
        .rd_addr(rd_addr), .serial(serial), .frame_start(frame_start),
        .grp_odd(grp_odd), .mode_act(mode_act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int satm(input logic [2:0] m);
        return (m > 3'd4) ? 4 : int'(m);
    endfunction

    // Synchronous buffer: data for a read appears the following cycle, otherwise garbage.
    initial begin
        logic          en;
        logic [AW-1:0] ad;
        forever begin
            @(negedge clk);
            en = rd_en;
            ad = rd_addr;
            @(posedge clk);
            #1;
            rd_data = en ? mem[ad] : WW'($urandom);
        end
    end

    // Reference model: every frame lasts FRAME cycles; the mode seen at its first edge fixes P and L.
    initial begin
        int         n, frStart, frMode, frames, nm, ns, p, l, w, b;
        bit         startHere, wordStart;
        logic       expSer, expFs, expGrp;
        logic [2:0] expMa;
        n = 0; frStart = 0; frMode = 4; frames = 0;
        expSer = 0; expFs = 0; expGrp = 0; expMa = 3'd4;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n = 0; frames = 0; frStart = 0; frMode = 4;
                expSer = 0; expFs = 0; expGrp = 0; expMa = 3'd4;
            end else begin
                startHere = (n == 2) || (n > 2 && n == frStart + FRAME);
                nm = startHere ? satm(mode) : frMode;
                ns = startHere ? n : frStart;
                p = BD << (4 - nm);
                l = 1 << (AW - 4 + nm);
                wordStart = (n >= 2) && ((n - ns) % (WW * p) == 0);
                w = (n >= 2) ? (n - ns) / (WW * p) : 0;
                b = (n >= 2) ? ((n - ns) / p) % WW : 0;
                chk("serial", serial, expSer);
                chk("frame_start", frame_start, expFs);
                chk("grp_odd", grp_odd, expGrp);
                chk("mode_act", mode_act, expMa);
                chk("rd_en", rd_en, (n == 0) || wordStart);
                if (n == 0 || wordStart) chk("rd_addr", rd_addr, (n == 0) ? 0 : (w + 1) % l);
                if (scbOn && rd_en && n >= 2 && n < 2 + 3 * FRAME) readCnt[rd_addr]++;
                if (n == 0) expMa = 3'(satm(mode));
                if (n >= 2) begin
                    if (startHere) begin
                        if (frames > 0) expGrp = ~expGrp;
                        frames++;
                        frStart = n;
                        frMode = nm;
                        expMa = 3'(nm);
                    end
                    expFs = startHere;
                    expSer = mem[w][WW-1-b];
                end
                n++;
            end
        end
    end

    task automatic goto(input int k);
        while (sc < k) begin
            @(negedge clk);
            sc++;
        end
    endtask

    task automatic resetOn();
        #2 reset = 1'b0;
    endtask

    task automatic release_rst();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        sc = -1;
    endtask

    task automatic setMode(input logic [2:0] m);
        @(posedge clk);
        #1 mode = m;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < (1 << AW); i++) mem[i] = WW'($urandom);
    endtask

    initial begin
        // M16 with word[k]=k
        resetOn();
        for (int i = 0; i < (1 << AW); i++) mem[i] = WW'(i);
        mode = 3'd4;
        release_rst();
        goto(0);
        chk("prime rd_en", rd_en, 1);
        chk("prime rd_addr", rd_addr, 0);
        chk("reset mode_act", mode_act, 4);
        chk("reset frame_start", frame_start, 0);
        goto(2);
        chk("first tick rd_en", rd_en, 1);
        chk("first tick rd_addr", rd_addr, 1);
        goto(3);
        chk("first frame_start", frame_start, 1);
        chk("word0 msb", serial, 0);
        chk("first grp_odd", grp_odd, 0);
        goto(4);
        chk("frame_start pulse", frame_start, 0);
        goto(50);
        chk("word1 read", rd_en, 1);
        chk("word1 read addr", rd_addr, 2);
        for (int k = 95; k <= 98; k++) begin
            goto(k);
            chk("word1 lsb hold", serial, 1);
        end
        goto(99);
        chk("word2 msb", serial, 0);
        goto(3026);
        chk("m16 wrap addr", rd_addr, 0);
        goto(3075);
        chk("frame2 start", frame_start, 1);
        chk("frame2 grp_odd", grp_odd, 1);

        // M1 with word[k]=0xA5A
        resetOn();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 12'hA5A;
        mode = 3'd0;
        release_rst();
        goto(3);
        chk("m1 bit11", serial, 1);
        goto(66);
        chk("m1 bit11 held", serial, 1);
        goto(67);
        chk("m1 bit10", serial, 0);
        goto(131);
        chk("m1 bit9", serial, 1);
        goto(770);
        chk("m1 addr2", rd_addr, 2);
        goto(2306);
        chk("m1 wrap addr", rd_addr, 0);
        chk("m1 wrap rd_en", rd_en, 1);
        goto(3075);
        chk("m1 frame2 start", frame_start, 1);
        chk("m1 frame2 grp", grp_odd, 1);
        goto(6147);
        chk("m1 frame3 start", frame_start, 1);
        chk("m1 frame3 grp", grp_odd, 0);

        // Mid-frame 4 -> 1, then a change that reverts before the boundary
        resetOn();
        fillRandom();
        mode = 3'd4;
        release_rst();
        goto(500);
        setMode(3'd1);
        goto(3026);
        chk("m16 held addr", rd_addr, 0);
        goto(3074);
        chk("m16 held mode_act", mode_act, 4);
        goto(3075);
        chk("switch mode_act", mode_act, 1);
        chk("switch frame_start", frame_start, 1);
        goto(3458);
        chk("m2 word1 read", rd_en, 1);
        chk("m2 word1 addr", rd_addr, 2);
        goto(4000);
        setMode(3'd2);
        goto(4500);
        setMode(3'd1);
        goto(6147);
        chk("revert mode_act", mode_act, 1);
        chk("revert frame_start", frame_start, 1);

        // mode=7 saturates to M16
        resetOn();
        fillRandom();
        mode = 3'd7;
        release_rst();
        goto(1);
        chk("sat mode_act", mode_act, 4);
        goto(3);
        chk("sat frame_start", frame_start, 1);
        goto(3200);

        // Reset at frame 2, word 37, bit 5
        resetOn();
        fillRandom();
        mem[37] = 12'hFFF;
        mode = 3'd4;
        release_rst();
        goto(4871);
        chk("pre-reset serial", serial, 1);
        chk("pre-reset grp_odd", grp_odd, 1);
        #2 reset = 1'b0;
        #1;
        chk("async serial", serial, 0);
        chk("async rd_en", rd_en, 0);
        chk("async rd_addr", rd_addr, 0);
        chk("async frame_start", frame_start, 0);
        chk("async grp_odd", grp_odd, 0);
        chk("async mode_act", mode_act, 4);
        release_rst();
        goto(0);
        chk("restart rd_en", rd_en, 1);
        chk("restart rd_addr", rd_addr, 0);
        goto(3);
        chk("restart frame_start", frame_start, 1);
        chk("restart grp_odd", grp_odd, 0);

        // Three M8 frames: every address in 0..31 read exactly once per frame
        resetOn();
        fillRandom();
        mode = 3'd3;
        for (int i = 0; i < (1 << AW); i++) readCnt[i] = 0;
        scbOn = 1'b1;
        release_rst();
        goto(2 + 3 * FRAME);
        scbOn = 1'b0;
        for (int i = 0; i < (1 << AW); i++) chk("m8 read count", readCnt[i], (i < 32) ? 3 : 0);

        // Random mode changes, including reverting and out-of-range values
        resetOn();
        fillRandom();
        mode = 3'($urandom_range(0, 7));
        release_rst();
        for (int i = 0; i < 12; i++) begin
            goto(sc + int'($urandom_range(100, 900)));
            setMode(3'($urandom_range(0, 7)));
        end
        goto(sc + 3200);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
